// File: rtl/dff_err_frame_serializer_pkg.sv
// Shared types and helpers for the DFF error-count readout path:
// frame constants, serial CRC-8 step and frame length.
package dff_readout_pkg;

   localparam logic [7:0] CRC8_POLY   = 8'h07;
   localparam logic [7:0] DEFAULT_HDR = 8'hA5;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      CRCOUT
   } state_e;

   // One MSB-first CRC-8 step: init 0, no reflection, no final XOR.
   function automatic logic [7:0] crc8_bit(input logic [7:0] crc,
                                           input logic       b);
      logic       fbk;
      logic [7:0] nxt;
      fbk = crc[7] ^ b;
      nxt = {crc[6:0], 1'b0};
      if (fbk) nxt = nxt ^ CRC8_POLY;
      return nxt;
   endfunction

   function automatic int frame_len(input int n_ch, input int cnt_w);
      return 8 + n_ch * cnt_w + 8;
   endfunction

endpackage

// File: rtl/dff_err_frame_serializer_sync.sv
// Synchroniser for one async RPi pin: SYNC_N flops, a history flop
// and a registered one-cycle rise pulse.
module async_edge_sync #(
   parameter int SYNC_N = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic pulse
);

   logic [SYNC_N-1:0] sync_q, sync_d;
   logic              hist_q, hist_d;
   logic              pulse_q, pulse_d;

   always_comb begin
      sync_d  = {sync_q[SYNC_N-2:0], pin};
      hist_d  = sync_q[SYNC_N-1];
      pulse_d = sync_q[SYNC_N-1] & ~hist_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         hist_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         hist_q  <= hist_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/dff_err_frame_serializer.sv
// Snapshots ERR_CNT on a save_req rise and shifts out HDR, payload and
// CRC-8 one bit per synchronised data_clk rise.
module dff_err_frame_serializer
   import dff_readout_pkg::*;
#(
   parameter int         N_CH   = 20,
   parameter int         CNT_W  = 12,
   parameter logic [7:0] HDR    = DEFAULT_HDR,
   parameter int         SYNC_N = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [N_CH*CNT_W-1:0] ERR_CNT,
   input  logic                  save_req,
   input  logic                  data_clk,
   output logic                  DATA_OUT,
   output logic                  BUSY,
   output logic                  FRAME_DONE,
   output logic                  OVERRUN
);

   localparam int PL    = 8 + N_CH * CNT_W;
   localparam int L     = frame_len(N_CH, CNT_W);
   localparam int IDX_W = $clog2(L + 1);
   localparam int FB_W  = 2 ** IDX_W;

   logic             save_p, clk_p;
   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d, idx_n;
   logic [7:0]       crc_q, crc_d, crc_n;
   logic             data_q, data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ovr_q, ovr_d;
   logic [CNT_W-1:0] snap_q [N_CH];
   logic [CNT_W-1:0] snap_d [N_CH];
   logic [FB_W-1:0]  fb;

   async_edge_sync #(.SYNC_N(SYNC_N)) u_save_sync (
      .clk   (CLK),
      .rst   (RST),
      .pin   (save_req),
      .pulse (save_p)
   );

   async_edge_sync #(.SYNC_N(SYNC_N)) u_dclk_sync (
      .clk   (CLK),
      .rst   (RST),
      .pin   (data_clk),
      .pulse (clk_p)
   );

   // fb[i] is frame bit i in transmit order; the index mux reads it.
   always_comb begin
      fb      = '0;
      fb[7:0] = {<<{HDR}};
      for (int c = 0; c < N_CH; c++)
         fb[8 + c*CNT_W +: CNT_W] = {<<{snap_q[c]}};
   end

   assign idx_n = idx_q + 1'b1;
   assign crc_n = crc8_bit(crc_q, fb[idx_q]);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (save_p) state_d = SHIFT;
         SHIFT:   if (clk_p && idx_n == IDX_W'(PL)) state_d = CRCOUT;
         CRCOUT:  if (clk_p && idx_n == IDX_W'(L)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      idx_d  = idx_q;
      crc_d  = crc_q;
      data_d = data_q;
      busy_d = busy_q;
      done_d = 1'b0;
      ovr_d  = ovr_q;
      snap_d = snap_q;
      unique case (state_q)
         IDLE: begin
            data_d = 1'b0;
            if (save_p) begin
               for (int c = 0; c < N_CH; c++)
                  snap_d[c] = ERR_CNT[c*CNT_W +: CNT_W];
               idx_d  = '0;
               crc_d  = 8'h00;
               data_d = HDR[7];
               busy_d = 1'b1;
            end
         end
         SHIFT: begin
            if (clk_p) begin
               idx_d  = idx_n;
               crc_d  = crc_n;
               data_d = (idx_n == IDX_W'(PL)) ? crc_n[7] : fb[idx_n];
            end
         end
         CRCOUT: begin
            if (clk_p) begin
               idx_d  = idx_n;
               crc_d  = {crc_q[6:0], 1'b0};
               data_d = crc_q[6];
               if (idx_n == IDX_W'(L)) begin
                  idx_d  = '0;
                  done_d = 1'b1;
                  busy_d = 1'b0;
                  data_d = 1'b0;
               end
            end
         end
         default: begin
            idx_d  = '0;
            data_d = 1'b0;
            busy_d = 1'b0;
         end
      endcase
      if (save_p && state_q != IDLE) ovr_d = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         idx_q   <= '0;
         crc_q   <= 8'h00;
         data_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
         for (int c = 0; c < N_CH; c++) snap_q[c] <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         crc_q   <= crc_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
         snap_q  <= snap_d;
      end
   end

   assign DATA_OUT   = data_q;
   assign BUSY       = busy_q;
   assign FRAME_DONE = done_q;
   assign OVERRUN    = ovr_q;

endmodule

// File: tb/tb_dff_err_frame_serializer.sv
// Bench for dff_err_frame_serializer: two instances (HDR A5 and 00) share
// stimulus; a frame/CRC model built by polynomial division predicts output.
module tb_dff_err_frame_serializer;

   localparam int N_CH  = 20;
   localparam int CNT_W = 12;
   localparam int W     = N_CH * CNT_W;
   localparam int L     = 8 + W + 8;

   logic         CLK = 1'b0;
   logic         RST;
   logic [W-1:0] ERR_CNT;
   logic         save_req, data_clk;
   logic         dout_a, busy_a, done_a, ovr_a;
   logic         dout_z, busy_z, done_z, ovr_z;

   int           n_chk = 0;
   int           n_fail = 0;
   int           done_cnt_a = 0;
   int           done_cnt_z = 0;
   int           k = 0;
   bit           scramble = 1'b0;
   logic [L-1:0] exp_a, exp_z;
   logic [19:0]  got;
   logic [7:0]   crc_got;
   logic         any_z;

   always #5 CLK = ~CLK;

   dff_err_frame_serializer u_dut_a (
      .CLK(CLK), .RST(RST), .ERR_CNT(ERR_CNT),
      .save_req(save_req), .data_clk(data_clk),
      .DATA_OUT(dout_a), .BUSY(busy_a),
      .FRAME_DONE(done_a), .OVERRUN(ovr_a)
   );

   dff_err_frame_serializer #(.HDR(8'h00)) u_dut_z (
      .CLK(CLK), .RST(RST), .ERR_CNT(ERR_CNT),
      .save_req(save_req), .data_clk(data_clk),
      .DATA_OUT(dout_z), .BUSY(busy_z),
      .FRAME_DONE(done_z), .OVERRUN(ovr_z)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Frame = {hdr, ch0..chN-1, crc}; crc is the remainder of msg*x^8 / 0x107.
   function automatic logic [L-1:0] model_frame(input logic [7:0] hdr,
                                                input logic [W-1:0] cnt);
      logic [L-1:0] f, v;
      f = '0;
      f[L-1 -: 8] = hdr;
      for (int c = 0; c < N_CH; c++)
         f[L-9 - c*CNT_W -: CNT_W] = cnt[c*CNT_W +: CNT_W];
      v = f;
      for (int i = L-1; i >= 8; i--)
         if (v[i]) v[i -: 9] = v[i -: 9] ^ 9'h107;
      f[7:0] = v[7:0];
      return f;
   endfunction

   function automatic logic [W-1:0] rnd_cnt();
      logic [W-1:0] r;
      for (int i = 0; i < W; i += 16) r[i +: 16] = 16'($urandom);
      return r;
   endfunction

   always @(negedge CLK) begin
      if (done_a) begin
         done_cnt_a++;
         chk("busy_at_done_a", busy_a, 0);
      end
      if (done_z) begin
         done_cnt_z++;
         chk("busy_at_done_z", busy_z, 0);
      end
   end

   always @(negedge CLK) if (scramble) ERR_CNT = rnd_cnt();

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic check_pos();
      logic ea, ez, eb;
      if (k < L) begin
         ea = exp_a[L-1-k];
         ez = exp_z[L-1-k];
         eb = 1'b1;
      end else begin
         ea = 1'b0;
         ez = 1'b0;
         eb = 1'b0;
      end
      chk($sformatf("data_a[%0d]", k), dout_a, ea);
      chk($sformatf("data_z[%0d]", k), dout_z, ez);
      chk($sformatf("busy_a[%0d]", k), busy_a, eb);
      chk($sformatf("busy_z[%0d]", k), busy_z, eb);
   endtask

   task automatic do_save();
      save_req = 1'b1;
      tick(4);
      save_req = 1'b0;
      tick(4);
   endtask

   task automatic do_edge();
      data_clk = 1'b1;
      tick($urandom_range(3, 8));
      data_clk = 1'b0;
      tick($urandom_range(3, 6));
      k++;
      check_pos();
   endtask

   task automatic start_frame();
      exp_a = model_frame(8'hA5, ERR_CNT);
      exp_z = model_frame(8'h00, ERR_CNT);
      done_cnt_a = 0;
      done_cnt_z = 0;
      k = 0;
   endtask

   task automatic check_idle(input string nm);
      chk({nm, "_data_a"}, dout_a, 0);
      chk({nm, "_busy_a"}, busy_a, 0);
      chk({nm, "_done_a"}, done_a, 0);
      chk({nm, "_data_z"}, dout_z, 0);
      chk({nm, "_busy_z"}, busy_z, 0);
      chk({nm, "_done_z"}, done_z, 0);
   endtask

   initial begin
      RST = 1'b1;
      save_req = 1'b0;
      data_clk = 1'b0;
      ERR_CNT = '0;
      tick(3);
      check_idle("reset");
      chk("reset_ovr_a", ovr_a, 0);
      chk("reset_ovr_z", ovr_z, 0);
      RST = 1'b0;
      tick(2);

      // ch0 = ABC, header bits then RST abandons the frame at bit 100
      ERR_CNT = '0;
      ERR_CNT[CNT_W-1:0] = 12'hABC;
      start_frame();
      do_save();
      check_pos();
      got = '0;
      repeat (20) begin
         got = {got[18:0], dout_a};
         do_edge();
      end
      chk("first20_bits", got, 20'hA5ABC);
      repeat (80) do_edge();
      RST = 1'b1;
      tick(1);
      check_idle("mid_rst");
      RST = 1'b0;
      tick(2);
      data_clk = 1'b1;
      tick(5);
      data_clk = 1'b0;
      tick(5);
      check_idle("idle_dclk");

      // ch19 = 1, mid-frame save, live counts scrambled after snapshot
      ERR_CNT = '0;
      ERR_CNT[W-1 -: CNT_W] = 12'h001;
      start_frame();
      do_save();
      check_pos();
      scramble = 1'b1;
      crc_got = '0;
      while (k < L) begin
         if (k >= L-8) crc_got = {crc_got[6:0], dout_z};
         do_edge();
         if (k == 50) begin
            do_save();
            chk("overrun_a", ovr_a, 1);
            chk("overrun_z", ovr_z, 1);
            check_pos();
         end
      end
      scramble = 1'b0;
      chk("crc_ch19_z", crc_got, 8'h07);
      chk("done_cnt_a", done_cnt_a, 1);
      chk("done_cnt_z", done_cnt_z, 1);
      chk("ovr_sticky_a", ovr_a, 1);
      chk("ovr_sticky_z", ovr_z, 1);
      RST = 1'b1;
      tick(2);
      RST = 1'b0;
      tick(2);
      chk("ovr_clr_a", ovr_a, 0);
      chk("ovr_clr_z", ovr_z, 0);

      // all-zero counts, save and data_clk rising together in IDLE
      ERR_CNT = '0;
      start_frame();
      save_req = 1'b1;
      data_clk = 1'b1;
      tick(4);
      save_req = 1'b0;
      data_clk = 1'b0;
      tick(4);
      check_pos();
      chk("start_bit_a", dout_a, 1);
      any_z = 1'b0;
      while (k < L) begin
         any_z = any_z | dout_z;
         do_edge();
      end
      chk("zero_frame_z", any_z, 0);
      chk("done_cnt3_a", done_cnt_a, 1);
      chk("done_cnt3_z", done_cnt_z, 1);

      // random counts, random edge timing
      repeat (2) begin
         ERR_CNT = rnd_cnt();
         start_frame();
         do_save();
         check_pos();
         scramble = 1'b1;
         while (k < L) do_edge();
         scramble = 1'b0;
         chk("done_cnt_rnd_a", done_cnt_a, 1);
         chk("done_cnt_rnd_z", done_cnt_z, 1);
         chk("ovr_rnd_a", ovr_a, 0);
      end

      tick(4);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
